// File: rtl/crossbar_rr.sv
// PORTS x PORTS crossbar with one round-robin arbiter per output port.
// A grant stays with its owner while it keeps requesting the same output, so packets are never interleaved.
module crossbar_rr #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PORTS-1:0][WIDTH-1:0]            data_i,
  input  logic [PORTS-1:0]                       bp_i,
  input  logic [PORTS-1:0][$clog2(PORTS)-1:0]    dest,
  input  logic [PORTS-1:0]                       dest_en,
  output logic [PORTS-1:0][WIDTH-1:0]            data_o,
  output logic [PORTS-1:0]                       data_o_en,
  output logic [PORTS-1:0]                       bp_o,
  output logic [PORTS-1:0]                       ack
);

  localparam int IW = $clog2(PORTS);

  logic [PORTS-1:0][IW-1:0] ptr_q, ptr_d;
  logic [PORTS-1:0][IW-1:0] owner_q, owner_d;
  logic [PORTS-1:0]         owner_vld_q, owner_vld_d;

  logic [PORTS-1:0][PORTS-1:0] req;
  logic [PORTS-1:0]            gnt_vld;
  logic [PORTS-1:0]            gnt_new;
  logic [PORTS-1:0][IW-1:0]    gnt_idx;
  logic [31:0]                 scan_idx;

  always_comb begin
    req = '0;
    for (int unsigned j = 0; j < PORTS; j++) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        req[j][i] = dest_en[i] && (dest[i] == IW'(j));
      end
    end
  end

  // Held owner wins outright; otherwise first requester found scanning from ptr.
  always_comb begin
    gnt_vld  = '0;
    gnt_new  = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned j = 0; j < PORTS; j++) begin
      if (owner_vld_q[j] && req[j][owner_q[j]]) begin
        gnt_vld[j] = 1'b1;
        gnt_idx[j] = owner_q[j];
      end else begin
        for (int unsigned k = 0; k < PORTS; k++) begin
          scan_idx = (32'(ptr_q[j]) + k) % PORTS;
          if (!gnt_vld[j] && req[j][IW'(scan_idx)]) begin
            gnt_vld[j] = 1'b1;
            gnt_new[j] = 1'b1;
            gnt_idx[j] = IW'(scan_idx);
          end
        end
      end
    end
  end

  always_comb begin
    data_o    = '0;
    data_o_en = '0;
    ack       = '0;
    bp_o      = '0;
    if (!rst) begin
      for (int unsigned j = 0; j < PORTS; j++) begin
        if (gnt_vld[j]) begin
          data_o[j]          = data_i[gnt_idx[j]];
          data_o_en[j]       = 1'b1;
          ack[gnt_idx[j]]    = 1'b1;
        end
      end
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (ack[i]) begin
          bp_o[i] = bp_i[dest[i]];
        end
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = gnt_vld;
    for (int unsigned j = 0; j < PORTS; j++) begin
      if (gnt_vld[j]) begin
        owner_d[j] = gnt_idx[j];
      end
      if (gnt_new[j]) begin
        ptr_d[j] = IW'((32'(gnt_idx[j]) + 32'd1) % PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
    end
  end

endmodule

// File: tb/tb_crossbar_rr.sv
// Directed self-checking bench for crossbar_rr (PORTS=4, WIDTH=8).
module tb_crossbar_rr;
  localparam int P = 4;
  localparam int W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [P-1:0][W-1:0]  data_i;
  logic [P-1:0]         bp_i;
  logic [P-1:0][1:0]    dest;
  logic [P-1:0]         dest_en;
  logic [P-1:0][W-1:0]  data_o;
  logic [P-1:0]         data_o_en;
  logic [P-1:0]         bp_o;
  logic [P-1:0]         ack;

  int total = 0;
  int bad   = 0;

  crossbar_rr #(.PORTS(P), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .bp_i(bp_i), .dest(dest),
    .dest_en(dest_en), .data_o(data_o), .data_o_en(data_o_en),
    .bp_o(bp_o), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_data, input logic [3:0] e_en,
                           input logic [3:0] e_ack, input logic [3:0] e_bp);
    check({tag, ".data_o"},    data_o,    e_data);
    check({tag, ".data_o_en"}, data_o_en, {28'd0, e_en});
    check({tag, ".ack"},       ack,       {28'd0, e_ack});
    check({tag, ".bp_o"},      bp_o,      {28'd0, e_bp});
  endtask

  initial begin
    rst     = 1'b1;
    data_i  = {8'h44, 8'h33, 8'h22, 8'h11};
    bp_i    = 4'b1111;
    dest    = '0;
    dest_en = 4'b1111;

    // reset forces all outputs low
    step(); #1;
    check_all("reset", 32'h0, 4'b0000, 4'b0000, 4'b0000);

    // first grant after reset: inputs 1,2 -> output 0, ptr 0 scan picks 1
    step();
    rst = 1'b0; dest_en = 4'b0110; #1;
    check_all("first_grant", 32'h0000_0022, 4'b0001, 4'b0010, 4'b0010);
    step(); dest_en = 4'b0000;

    // single path 2 -> 3
    step();
    data_i[2] = 8'hA5; dest[2] = 2'd3; dest_en = 4'b0100; bp_i = 4'b1000; #1;
    check_all("single_bp1", 32'hA500_0000, 4'b1000, 4'b0100, 4'b0100);
    step(); bp_i = 4'b0000; #1;
    check_all("single_bp0", 32'hA500_0000, 4'b1000, 4'b0100, 4'b0000);
    step(); dest_en = 4'b0000; bp_i = 4'b1111; data_i[2] = 8'h33;

    // contention on output 1 (ptr1 = 0): input 0 wins and holds
    step();
    dest[0] = 2'd1; dest[2] = 2'd1; dest_en = 4'b0101; #1;
    check_all("contend", 32'h0000_1100, 4'b0010, 4'b0001, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      check("hold.ack",    ack,    32'h1);
      check("hold.data_o", data_o, 32'h0000_1100);
    end
    step(); dest_en = 4'b0100; #1;
    check_all("release", 32'h0000_3300, 4'b0010, 4'b0100, 4'b0100);
    step(); dest_en = 4'b0000;

    // parallel permutation 0->1, 1->2, 2->3, 3->0
    step();
    dest = {2'd0, 2'd3, 2'd2, 2'd1}; dest_en = 4'b1111; #1;
    check_all("parallel", 32'h3322_1144, 4'b1111, 4'b1111, 4'b1111);
    step(); dest_en = 4'b0000;

    // round-robin on output 0 (ptr0 = 0): each winner sits out one cycle
    step();
    dest = '0; dest_en = 4'b1111; #1;
    check("rr0.ack", ack, 32'h1); check("rr0.data_o", data_o, 32'h11);
    step(); dest_en = 4'b1110; #1;
    check("rr1.ack", ack, 32'h2); check("rr1.data_o", data_o, 32'h22);
    step(); dest_en = 4'b1101; #1;
    check("rr2.ack", ack, 32'h4); check("rr2.data_o", data_o, 32'h33);
    step(); dest_en = 4'b1011; #1;
    check("rr3.ack", ack, 32'h8); check("rr3.data_o", data_o, 32'h44);
    step(); dest_en = 4'b0111; #1;
    check("rr4.ack", ack, 32'h1); check("rr4.data_o", data_o, 32'h11);
    step(); dest_en = 4'b0000;

    // reset mid-packet: input 1 holds output 2, then rst pulses
    step();
    dest[1] = 2'd2; dest_en = 4'b0010; #1;
    check_all("pkt", 32'h0022_0000, 4'b0100, 4'b0010, 4'b0010);
    step(); rst = 1'b1; #1;
    check_all("pkt_rst", 32'h0, 4'b0000, 4'b0000, 4'b0000);
    // fresh arbitration from ptr 0 with inputs 0,1,3 all requesting output 2
    step();
    rst = 1'b0; dest[0] = 2'd2; dest[3] = 2'd2; dest_en = 4'b1011; #1;
    check_all("post_rst", 32'h0011_0000, 4'b0100, 4'b0001, 4'b0001);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crossbar_rr.md
Name: crossbar_rr

Overview:
- PORTS x PORTS crossbar with a round-robin arbiter per output port, used inside each NoC router node.
- Each input requests one output via a destination index. Each output grants one requester, forwards that input's data forward, and routes the output's backpressure/ack back to the granted input.
- Grants persist while the owner keeps requesting, so wormhole packets are never interleaved.

Parameters:
- PORTS, 4, number of input ports and output ports (>=2).
- WIDTH, 8, data word width in bits (the node uses flit width + 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  PORTS x WIDTH  data word per input port.
- bp_i  in  PORTS x 1  ack/backpressure from the downstream side of each output port.
- dest  in  PORTS x $clog2(PORTS)  requested output index per input (value k selects output k; node direction enum value).
- dest_en  in  PORTS x 1  request valid per input.
- data_o  out  PORTS x WIDTH  data word per output port.
- data_o_en  out  PORTS x 1  output j currently carries a granted input.
- bp_o  out  PORTS x 1  ack returned to each input port.
- ack  out  PORTS x 1  input i holds a grant this cycle.

Behaviour:
- Request matrix: req[j][i] = dest_en[i] && dest[i]==j.
- State per output j (registered): ptr[j] (round-robin priority index), owner[j], owner_vld[j].
- Grant is combinational from current requests and registered state; zero-cycle latency from request to data/ack.
- Grant rule for output j:
  - If owner_vld[j] && req[j][owner[j]], grant owner[j] (hold/lock).
  - Otherwise grant the first requesting i scanning ptr[j], ptr[j]+1, … mod PORTS.
  - If no requester, no grant.
- Each input requests only one output, so an input is granted by at most one output.
- Outputs:
  - data_o[j] = data_i[g] and data_o_en[j] = 1 when output j grants input g.
  - Otherwise data_o[j] = 0 and data_o_en[j] = 0.
  - ack[i] = 1 iff input i is granted by its requested output.
  - bp_o[i] = bp_i[dest[i]] when ack[i], else 0.
- Clock update per output j:
  - owner[j] <= g and owner_vld[j] <= 1 when granted, else owner_vld[j] <= 0.
  - ptr[j] <= (g+1) mod PORTS only when a new (non-held) grant is issued.
  - ptr[j] is unchanged while holding or idle.
- Lock release: the owner deasserting dest_en, or changing dest, frees the output that same cycle. A waiting requester can win combinationally in the same cycle.
- Reset, synchronous: ptr = 0, owner_vld = 0, owner = 0.
  - While rst is high, all outputs are forced to 0 (data_o, data_o_en, ack, bp_o).
  - Reset mid-packet drops all grants; the first cycle after release arbitrates fresh from ptr 0.
- Simultaneous requests to distinct outputs are all granted in parallel; no cross-output interaction.
- Hold semantics:
  - A held grant blocks other requesters indefinitely; starvation is avoided only by packet termination.
  - Fairness rotates on every new grant.
- No X propagation: unselected outputs drive 0.

Test Plan (PORTS=4, WIDTH=8):
- Reset: rst=1 with dest_en=4'b1111 → all data_o=0, data_o_en=0, ack=0, bp_o=0; after rst=0 the first grant of output 0 with inputs 1,2 requesting goes to input 1 (ptr 0 scan).
- Single path: input 2 dest=3, dest_en=1, data_i[2]=8'hA5, bp_i[3]=1 → same cycle data_o[3]=A5, data_o_en[3]=1, ack[2]=1, bp_o[2]=1. With bp_i[3]=0 → bp_o[2]=0 while ack[2]=1.
- Parallel: inputs 0→1, 1→2, 2→3, 3→0 simultaneously → all four acks 1, each data_o carries its source word.
- Contention + hold: inputs 0 and 2 both request output 1 → input 0 granted; it stays granted for 5 cycles while input 2 waits (ack[2]=0). Input 0 drops dest_en → input 2 granted that same cycle.
- Round-robin: inputs 0,1,2,3 all request output 0 and each releases for one cycle after winning → grant order 0,1,2,3,0.
- Reset mid-packet: input 1 holding output 2 and rst pulses one cycle → outputs 0 during rst; afterwards arbitration restarts with ptr=0.
